layer_lut_sequencer: RTL and testbench
======================================

# layer_lut_sequencer

Time-multiplexed evaluator for one LogicNets layer: a single shared 6-input truth-table read port is sequenced across `N` neurons, one neuron per clock. The block accepts an input feature vector on a valid/ready handshake and gathers each neuron's six fan-in bits through a per-neuron select table. It looks up the neuron's 64-entry truth table and assembles the `N` one-bit outputs into an output vector, which it presents on a second valid/ready handshake. It sits between layer stages where area matters more than throughput, replacing `N` parallel per-neuron LUT modules. Truth tables and fan-in selects are loaded at runtime through a config port.

## Interface
- `IN_W`, default 64: input feature vector width.
- `N`, default 16: neurons in the layer; `N` ≥ 2.
- `SEL_W`, default `$clog2(IN_W)`: width of one fan-in index.
- `NID_W`, default `$clog2(N)`: neuron index width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_data`  in  `IN_W`: input feature vector.
- `in_valid`  in  1: input vector present.
- `in_ready`  out  1: block can accept a vector.
- `out_data`  out  `N`: neuron output vector; bit n is neuron n.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: downstream accepts `out_data`.
- `cfg_we`  in  1: config write strobe.
- `cfg_neuron`  in  `NID_W`: neuron being configured.
- `cfg_table`  in  64: truth table; bit a is the output for address a.
- `cfg_sel`  in  `6*SEL_W`: fan-in indices; slice j is the index for fan-in j.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - `in_ready` = !`cfg_we`.
  - `cfg_we`=1 writes `cfg_table` and `cfg_sel` for `cfg_neuron` at the clock edge. Config wins over a simultaneous `in_valid`.
  - `in_valid`&&`in_ready` captures `in_data` into `vec_r`, clears the neuron counter `k` to 0 and `out_data` to 0, and moves to EVAL.
- EVAL, each cycle:
  - Address bit j is `addr[j]` = `vec_r[sel[k][j]]`, with j=0 as LSB.
  - The block writes `out_data[k]` = `table[k][addr]`.
  - If `k`==N-1, the next state is DONE; otherwise `k`++.
- DONE:
  - `out_valid`=1; `out_data` holds stable.
  - `out_ready`=1 moves to IDLE at that edge. `out_valid` drops; `out_data` retains its value.
- Outside IDLE:
  - `cfg_we` is ignored, and no table or select changes.
  - `in_ready`=0.
- Fan-in index ≥ `IN_W`: the selected bit reads as 0.
- `cfg_neuron` ≥ N: the write is ignored.
- Reset, including mid-EVAL or mid-DONE:
  - state←IDLE, `k`←0, `vec_r`←0, `out_data`←0, `out_valid`←0.
  - All tables←0 and all selects←0.
  - `busy`←0. `in_ready` reads 1 while `cfg_we`=0.
  - Any in-flight vector is discarded.

## Timing
- Latency: an accept at edge E0 gives `out_valid`=1 in the cycle after edge E0+N. There are exactly N EVAL cycles.
- Throughput: one vector every N+2 cycles with `out_ready` held at 1. Accept and output never overlap.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only. `in_ready` additionally depends combinationally on `cfg_we`.
- Table read is combinational, distributed-ROM style, within the EVAL cycle. The `out_data` bit is registered.
- A config write at edge E is visible to a vector accepted at E+1 or later.

## Structure
- Package `logicnets_seq_pkg` holds:
  - `FANIN`=6 and `TABLE_W`=64.
  - State enum `seq_state_t` {IDLE, EVAL, DONE}.
- Sub-module `lut_bank` holds:
  - N×64 table registers and N×6×`SEL_W` select registers, both with asynchronous clear.
  - The write port.
  - The combinational mux giving the table bit for (`k`, `vec_r`).
- The top level holds the FSM, counter, input capture and output register.

## Test plan
- **Reset and idle**: drive `rst` mid-EVAL.
  - Immediately: `out_valid`=0, `out_data`=0, `busy`=0.
  - After release, with `cfg_we`=0: `in_ready`=1.
- **AND neuron**: configure neuron 0 with table=64'h8000_0000_0000_0000 and sel={5,4,3,2,1,0}, all other tables 0.
  - `in_data`=64'h3F gives `out_data`=16'h0001.
  - `in_data`=64'h1F gives 16'h0000.
- **Select routing and latency**: configure neuron 15 with table=64'hAAAA_AAAA_AAAA_AAAA (out=addr[0]) and sel[0]=63; send `in_data`=1<<63.
  - `out_data`=16'h8000.
  - `out_valid` rises exactly 16 edges after the accept edge.
- **Backpressure**: hold `out_ready`=0 for 10 cycles in DONE.
  - `out_data` stays stable.
  - `in_ready`=0 and `busy`=1 throughout.
  - Releasing `out_ready` returns to IDLE in 1 cycle.
- **Config collision**: assert `cfg_we` and `in_valid` together in IDLE.
  - The write is applied and the vector is not accepted (`in_ready`=0).
  - A `cfg_we` pulse during EVAL changes no table; a readback vector confirms the old function.
- **Back-to-back**: send 4 vectors with `out_ready`=1 and a random table.
  - Outputs match the reference model.
  - Consecutive accepts are spaced exactly N+2 cycles apart.

Source files
------------

// File: rtl/layer_lut_sequencer_pkg.sv
// Shared definitions for the time-multiplexed LogicNets layer evaluator.
//   FANIN       : fan-in bits per neuron (truth-table address width)
//   TABLE_W     : truth-table entries per neuron (2**FANIN)
//   seq_state_t : sequencer FSM states
package logicnets_seq_pkg;

  localparam int unsigned FANIN   = 6;
  localparam int unsigned TABLE_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/layer_lut_sequencer_lut_bank.sv
// Per-neuron truth tables and fan-in selects with a single combinational
// read port.
//   clk, rst   : clock, asynchronous active-high clear of all tables/selects
//   we         : write strobe (already qualified by the sequencer)
//   wr_neuron  : neuron to write; values >= N are ignored
//   wr_table   : truth table, bit a is the output for address a
//   wr_sel     : six fan-in indices, slice j drives address bit j
//   rd_k       : neuron being evaluated
//   rd_vec     : captured input feature vector
//   rd_bit     : table[rd_k][addr] with addr gathered from rd_vec
module lut_bank
  import logicnets_seq_pkg::*;
#(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned N     = 16,
  parameter int unsigned SEL_W = $clog2(IN_W),
  parameter int unsigned NID_W = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [NID_W-1:0]       wr_neuron,
  input  logic [TABLE_W-1:0]     wr_table,
  input  logic [FANIN*SEL_W-1:0] wr_sel,
  input  logic [NID_W-1:0]       rd_k,
  input  logic [IN_W-1:0]        rd_vec,
  output logic                   rd_bit
);

  logic [TABLE_W-1:0]     table_q [N];
  logic [TABLE_W-1:0]     table_d [N];
  logic [FANIN*SEL_W-1:0] sel_q   [N];
  logic [FANIN*SEL_W-1:0] sel_d   [N];

  always_comb begin
    table_d = table_q;
    sel_d   = sel_q;
    if (we && (32'(wr_neuron) < N)) begin
      table_d[wr_neuron] = wr_table;
      sel_d[wr_neuron]   = wr_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        table_q[i] <= '0;
        sel_q[i]   <= '0;
      end
    end else begin
      table_q <= table_d;
      sel_q   <= sel_d;
    end
  end

  logic [FANIN*SEL_W-1:0] rd_sel;
  logic [SEL_W-1:0]       idx;
  logic [FANIN-1:0]       addr;

  // Indices past the end of the feature vector read as 0.
  always_comb begin
    rd_sel = sel_q[rd_k];
    idx    = '0;
    addr   = '0;
    for (int unsigned j = 0; j < FANIN; j++) begin
      idx = rd_sel[j*SEL_W +: SEL_W];
      if (32'(idx) < IN_W) addr[j] = rd_vec[idx];
    end
    rd_bit = table_q[rd_k][addr];
  end

endmodule

// File: rtl/layer_lut_sequencer.sv
// Evaluates one LogicNets layer by sequencing a shared 6-input LUT read
// across N neurons, one neuron per clock.
//   clk, rst              : clock, asynchronous active-high reset
//   in_data/valid/ready   : input feature vector handshake
//   out_data/valid/ready  : N-bit neuron output handshake (bit n = neuron n)
//   cfg_we/neuron/table/sel : runtime table/select write, honoured in IDLE only
//   busy                  : high whenever the sequencer is not IDLE
module layer_lut_sequencer
  import logicnets_seq_pkg::*;
#(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned N     = 16,
  parameter int unsigned SEL_W = $clog2(IN_W),
  parameter int unsigned NID_W = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   cfg_we,
  input  logic [NID_W-1:0]       cfg_neuron,
  input  logic [TABLE_W-1:0]     cfg_table,
  input  logic [FANIN*SEL_W-1:0] cfg_sel,
  output logic                   busy
);

  seq_state_t       state_q, state_d;
  logic [NID_W-1:0] k_q, k_d;
  logic [IN_W-1:0]  vec_q, vec_d;
  logic [N-1:0]     out_q, out_d;
  logic             bank_we;
  logic             lut_bit;
  logic             accept;

  // Config has priority over an incoming vector in IDLE.
  assign in_ready  = (state_q == IDLE) && !cfg_we;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_q;
  assign bank_we   = cfg_we && (state_q == IDLE);
  assign accept    = in_valid && in_ready;

  lut_bank #(
    .IN_W (IN_W),
    .N    (N),
    .SEL_W(SEL_W),
    .NID_W(NID_W)
  ) u_lut_bank (
    .clk      (clk),
    .rst      (rst),
    .we       (bank_we),
    .wr_neuron(cfg_neuron),
    .wr_table (cfg_table),
    .wr_sel   (cfg_sel),
    .rd_k     (k_q),
    .rd_vec   (vec_q),
    .rd_bit   (lut_bit)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    vec_d   = vec_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          vec_d   = in_data;
          k_d     = '0;
          out_d   = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        out_d[k_q] = lut_bit;
        if (k_q == NID_W'(N - 1)) state_d = DONE;
        else                      k_d     = k_q + 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      vec_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      vec_q   <= vec_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_layer_lut_sequencer.sv
// Self-checking bench for layer_lut_sequencer: table-driven vectors,
// hand-written corner sequences and a scoreboard queue drained by a monitor.
module tb_layer_lut_sequencer;

  localparam int unsigned IN_W  = 64;
  localparam int unsigned N     = 16;
  localparam int unsigned SEL_W = 6;
  localparam int unsigned NID_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      out_data;
  logic              out_valid;
  logic              out_ready;
  logic              cfg_we;
  logic [NID_W-1:0]  cfg_neuron;
  logic [63:0]       cfg_table;
  logic [6*SEL_W-1:0] cfg_sel;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int acc_hist[$];
  logic [N-1:0] exp_q[$];
  logic prev_v = 1'b0;

  logic [63:0] m_table [N];
  int          m_sel   [N][6];

  typedef struct {
    logic [63:0] vin;
    logic [15:0] vexp;
  } vec_t;
  vec_t vt[6];

  layer_lut_sequencer #(
    .IN_W(IN_W),
    .N   (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cfg_we    (cfg_we),
    .cfg_neuron(cfg_neuron),
    .cfg_table (cfg_table),
    .cfg_sel   (cfg_sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] model(input logic [63:0] v);
    logic [N-1:0] r;
    logic [5:0]   a;
    r = '0;
    for (int n = 0; n < N; n++) begin
      a = '0;
      for (int j = 0; j < 6; j++)
        if (m_sel[n][j] < IN_W) a[j] = v[m_sel[n][j]];
      r[n] = m_table[n][a];
    end
    return r;
  endfunction

  function automatic logic [35:0] mk_sel(input int s5, input int s4, input int s3,
                                         input int s2, input int s1, input int s0);
    return {6'(s5), 6'(s4), 6'(s3), 6'(s2), 6'(s1), 6'(s0)};
  endfunction

  task automatic model_clear();
    for (int n = 0; n < N; n++) begin
      m_table[n] = '0;
      for (int j = 0; j < 6; j++) m_sel[n][j] = 0;
    end
  endtask

  // Called at posedge+1 while IDLE; updates the model as well.
  task automatic cfg_ok(input int n, input logic [63:0] t, input logic [35:0] s);
    cfg_we     = 1'b1;
    cfg_neuron = NID_W'(n);
    cfg_table  = t;
    cfg_sel    = s;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    m_table[n] = t;
    for (int j = 0; j < 6; j++) m_sel[n][j] = int'(s[j*6 +: 6]);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [63:0] d, input logic [N-1:0] e);
    bit ok;
    ok = 1'b0;
    exp_q.push_back(e);
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready never rose");
      in_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
    acc_hist.push_back(cyc);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d outputs outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [35:0] s;
    logic [63:0] v;
    bit          seen;

    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_neuron = '0; cfg_table = '0; cfg_sel = '0;
    model_clear();

    vt[0] = '{64'h0000_0000_0000_003F, 16'h0001};
    vt[1] = '{64'h0000_0000_0000_001F, 16'h0000};
    vt[2] = '{64'h0000_0000_0000_00FF, 16'h0001};
    vt[3] = '{64'h0000_0000_0000_003E, 16'h0000};
    vt[4] = '{64'h0000_0000_0000_0000, 16'h0000};
    vt[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 16'h0001};

    // Scoreboard monitor: one pop per output handshake, latency on each rise.
    fork
      forever begin
        @(negedge clk);
        if (rst) prev_v = 1'b0;
        else begin
          if (out_valid && !prev_v) chk("latency", 64'(cyc - acc_cyc), 64'(N));
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_output: got %h", out_data);
            end else chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
          end
          prev_v = out_valid;
        end
      end
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data",  64'(out_data),  0);
    chk("rst_busy",      64'(busy),      0);
    chk("rst_in_ready",  64'(in_ready),  1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // AND neuron, table-driven
    cfg_ok(0, 64'h8000_0000_0000_0000, mk_sel(5, 4, 3, 2, 1, 0));
    for (int i = 0; i < 6; i++) begin
      send(vt[i].vin, vt[i].vexp);
      drain();
    end

    // Select routing from bit 63 into neuron 15
    cfg_ok(15, 64'hAAAA_AAAA_AAAA_AAAA, mk_sel(0, 0, 0, 0, 0, 63));
    send(64'h8000_0000_0000_0000, 16'h8000);
    drain();

    // Backpressure in DONE
    out_ready = 1'b0;
    send(64'h8000_0000_0000_003F, 16'h8001);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_reached_done", 64'(seen), 1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_out_data",  64'(out_data),  64'h8001);
      chk("bp_out_valid", 64'(out_valid), 1);
      chk("bp_in_ready",  64'(in_ready),  0);
      chk("bp_busy",      64'(busy),      1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_busy",      64'(busy),      0);
    chk("bp_release_out_valid", 64'(out_valid), 0);
    chk("bp_release_hold_data", 64'(out_data),  64'h8001);
    drain();

    // Config collides with in_valid in IDLE: config wins
    cfg_we = 1'b1; cfg_neuron = 4'd1; cfg_table = '1; cfg_sel = '0;
    in_data = '0; in_valid = 1'b1;
    @(negedge clk);
    chk("collide_in_ready", 64'(in_ready), 0);
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("collide_not_accepted", 64'(busy), 0);
    m_table[1] = '1;
    send(64'h0, 16'h0002);
    drain();

    // cfg_we during EVAL must not modify neuron 0
    send(64'h3F, 16'h0003);
    cfg_we = 1'b1; cfg_neuron = 4'd0; cfg_table = '0; cfg_sel = '1;
    repeat (3) @(posedge clk);
    #1 cfg_we = 1'b0;
    drain();
    send(64'h3F, 16'h0003);
    drain();

    // Random tables, back-to-back vectors
    for (int n = 0; n < N; n++) begin
      for (int j = 0; j < 6; j++) s[j*6 +: 6] = 6'($urandom_range(0, 63));
      cfg_ok(n, {$urandom, $urandom}, s);
    end
    acc_hist.delete();
    for (int i = 0; i < 4; i++) begin
      v = {$urandom, $urandom};
      send(v, model(v));
    end
    drain();
    chk("b2b_accepts", 64'(acc_hist.size()), 4);
    for (int i = 1; i < acc_hist.size(); i++)
      chk("b2b_spacing", 64'(acc_hist[i] - acc_hist[i-1]), 64'(N + 2));

    // Reset in the middle of EVAL
    v = {$urandom, $urandom};
    send(v, model(v));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    model_clear();
    chk("midrst_out_valid", 64'(out_valid), 0);
    chk("midrst_out_data",  64'(out_data),  0);
    chk("midrst_busy",      64'(busy),      0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1;
    send(64'h3F, 16'h0000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
